// File: rtl/calc_pkg.sv
// Shared types for the calculator function unit: default widths, the
// sequencer state encoding and the decimal status flag bundle.
package calc_pkg;

    localparam int MANT_W_DEF = 34;
    localparam int EXP_W_DEF  = 7;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MUL   = 3'd1,
        S_NORM  = 3'd2,
        S_ROUND = 3'd3,
        S_PACK  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    typedef struct packed {
        logic ovf;
        logic unf;
        logic inexact;
    } dec_flags_t;

endpackage

// File: rtl/dec_div10.sv
// Combinational divide-by-ten: quotient plus the dropped decimal digit.
// Shared with the divider and the binary-to-digit formatter.
module dec_div10 #(
    parameter int W = 68
) (
    input  logic [W-1:0] din,
    output logic [W-1:0] quot,
    output logic [3:0]   rem
);

    localparam logic [W-1:0] TEN = W'(10);

    assign quot = din / TEN;
    assign rem  = 4'(din % TEN);

endmodule

// File: rtl/dec_mul_seq.sv
// Sequential decimal floating-point multiplier: MSB-first shift-add mantissa
// product, then divide-by-ten normalization, round-half-up and range check.
module dec_mul_seq
    import calc_pkg::*;
#(
    parameter int MANT_W = MANT_W_DEF,
    parameter int EXP_W  = EXP_W_DEF
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     eval,
    input  logic                     signA,
    input  logic                     signB,
    input  logic        [MANT_W-1:0] mantA,
    input  logic        [MANT_W-1:0] mantB,
    input  logic signed [EXP_W-1:0]  expA,
    input  logic signed [EXP_W-1:0]  expB,
    output logic                     busy,
    output logic                     done,
    output logic                     signRes,
    output logic        [MANT_W-1:0] mantRes,
    output logic signed [EXP_W-1:0]  expRes,
    output logic                     ovf,
    output logic                     unf,
    output logic                     inexact,
    output state_t                   stateDbg
);

    localparam int PW = 2 * MANT_W;
    localparam int XW = EXP_W + 2;
    localparam int CW = $clog2(MANT_W + 1);

    localparam logic [PW-1:0]        M_MAX_P = {{MANT_W{1'b0}}, {MANT_W{1'b1}}};
    localparam logic signed [XW-1:0] E_MAX_X = XW'(2 ** (EXP_W - 1) - 1);
    localparam logic signed [XW-1:0] E_MIN_X = XW'(-(2 ** (EXP_W - 1)));

    state_t                 state;
    logic                   evalPrev;
    logic                   doEval;
    logic [MANT_W-1:0]      opA;
    logic [MANT_W-1:0]      opB;
    logic [PW-1:0]          prod;
    logic signed [XW-1:0]   expSum;
    logic [CW-1:0]          bitCnt;
    logic [3:0]             rdig;
    logic                   sticky;
    logic                   inexW;
    logic                   signW;
    dec_flags_t             flags;

    logic [PW-1:0]          prodDiv10;
    logic [3:0]             remDiv10;
    logic [PW-1:0]          addend;
    logic                   roundUp;
    logic [PW-1:0]          prodRnd;

    // Handshake: a rising edge of the level input eval is accepted only in
    // S_IDLE; busy stays high until the cycle done pulses for one cycle, and
    // the result outputs are valid from that cycle until the next completion.
    assign doEval   = eval & ~evalPrev;
    assign busy     = (state != S_IDLE);
    assign stateDbg = state;
    assign ovf      = flags.ovf;
    assign unf      = flags.unf;
    assign inexact  = flags.inexact;

    dec_div10 #(.W(PW)) uDiv10 (
        .din  (prod),
        .quot (prodDiv10),
        .rem  (remDiv10)
    );

    assign addend  = opB[MANT_W-1] ? {{MANT_W{1'b0}}, opA} : '0;
    assign roundUp = (rdig >= 4'd5);
    assign prodRnd = prod + PW'(roundUp);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            evalPrev <= 1'b0;
            opA      <= '0;
            opB      <= '0;
            prod     <= '0;
            expSum   <= '0;
            bitCnt   <= '0;
            rdig     <= '0;
            sticky   <= 1'b0;
            inexW    <= 1'b0;
            signW    <= 1'b0;
            done     <= 1'b0;
            signRes  <= 1'b0;
            mantRes  <= '0;
            expRes   <= '0;
            flags    <= '0;
        end else begin
            evalPrev <= eval;
            done     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (doEval) begin
                        opA    <= mantA;
                        opB    <= mantB;
                        signW  <= signA ^ signB;
                        expSum <= {{2{expA[EXP_W-1]}}, expA} + {{2{expB[EXP_W-1]}}, expB};
                        prod   <= '0;
                        bitCnt <= '0;
                        rdig   <= '0;
                        sticky <= 1'b0;
                        inexW  <= 1'b0;
                        if (mantA == '0 || mantB == '0) begin
                            signRes <= 1'b0;
                            mantRes <= '0;
                            expRes  <= '0;
                            flags   <= '0;
                            state   <= S_DONE;
                        end else begin
                            state <= S_MUL;
                        end
                    end
                end
                S_MUL: begin
                    // Multiplier bits consumed MSB-first, so the product shifts left.
                    prod   <= {prod[PW-2:0], 1'b0} + addend;
                    opB    <= {opB[MANT_W-2:0], 1'b0};
                    bitCnt <= bitCnt + CW'(1);
                    if (bitCnt == CW'(MANT_W - 1)) begin
                        state <= S_NORM;
                    end
                end
                S_NORM: begin
                    if (prod > M_MAX_P) begin
                        prod   <= prodDiv10;
                        rdig   <= remDiv10;
                        sticky <= sticky | (rdig != 4'd0);
                        expSum <= expSum + XW'(1);
                    end else begin
                        state <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    prod  <= prodRnd;
                    inexW <= sticky | (rdig != 4'd0);
                    if (prodRnd > M_MAX_P) begin
                        rdig  <= '0;
                        state <= S_NORM;
                    end else begin
                        state <= S_PACK;
                    end
                end
                S_PACK: begin
                    if (expSum > E_MAX_X) begin
                        signRes <= signW;
                        mantRes <= '1;
                        expRes  <= E_MAX_X[EXP_W-1:0];
                        flags   <= '{ovf: 1'b1, unf: 1'b0, inexact: inexW};
                    end else if (expSum < E_MIN_X) begin
                        signRes <= 1'b0;
                        mantRes <= '0;
                        expRes  <= '0;
                        flags   <= '{ovf: 1'b0, unf: 1'b1, inexact: inexW};
                    end else begin
                        signRes <= signW;
                        mantRes <= prod[MANT_W-1:0];
                        expRes  <= expSum[EXP_W-1:0];
                        flags   <= '{ovf: 1'b0, unf: 1'b0, inexact: inexW};
                    end
                    state <= S_DONE;
                end
                S_DONE: begin
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dec_mul_seq.sv
// Self-checking bench for dec_mul_seq: directed test-plan cases, control
// scenarios and randomized operands against an arithmetic reference model.
module tb_dec_mul_seq;
    import calc_pkg::*;

    localparam int W  = 34;
    localparam int EW = 7;
    localparam logic [79:0] MMAX = 80'h3_FFFF_FFFF;

    logic          clock;
    logic          reset;
    logic          eval;
    logic          signA, signB;
    logic [W-1:0]  mantA, mantB;
    logic [EW-1:0] expA, expB;
    logic          busy, done, signRes;
    logic [W-1:0]  mantRes;
    logic [EW-1:0] expRes;
    logic          ovf, unf, inexact;
    state_t        stateDbg;

    int n_cmp = 0;
    int n_err = 0;
    logic [44:0] exp_q[$];
    logic [44:0] last_res = '0;

    dec_mul_seq #(.MANT_W(W), .EXP_W(EW)) dut (
        .clock   (clock),
        .reset   (reset),
        .eval    (eval),
        .signA   (signA),
        .signB   (signB),
        .mantA   (mantA),
        .mantB   (mantB),
        .expA    (expA),
        .expB    (expB),
        .busy    (busy),
        .done    (done),
        .signRes (signRes),
        .mantRes (mantRes),
        .expRes  (expRes),
        .ovf     (ovf),
        .unf     (unf),
        .inexact (inexact),
        .stateDbg(stateDbg)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic logic [44:0] out_vec();
        return {signRes, mantRes, expRes, ovf, unf, inexact};
    endfunction

    // Reference: smallest k such that round-half-up(P / 10^k) fits the mantissa.
    function automatic logic [44:0] model(input logic sa, input logic sb,
                                          input logic [W-1:0] ma, input logic [W-1:0] mb,
                                          input int ea, input int eb,
                                          output int kfl, output bit rr);
        logic [79:0] p, pw, q, r, rnd;
        int k, e;
        logic inx, s;
        kfl = 0;
        rr  = 1'b0;
        if (ma == '0 || mb == '0) return '0;
        p   = 80'(ma) * 80'(mb);
        pw  = 80'd1;
        k   = 0;
        kfl = -1;
        q   = '0;
        r   = '0;
        rnd = '0;
        while (k < 30) begin
            q = p / pw;
            r = p % pw;
            if (kfl < 0 && q <= MMAX) kfl = k;
            rnd = q + ((k > 0 && 2 * r >= pw) ? 80'd1 : 80'd0);
            if (rnd <= MMAX) break;
            pw = pw * 80'd10;
            k++;
        end
        rr  = (k != kfl);
        inx = (r != '0);
        s   = sa ^ sb;
        e   = ea + eb + k;
        if (e > 63)       return {s, 34'h3_FFFF_FFFF, 7'd63, 1'b1, 1'b0, inx};
        else if (e < -64) return {1'b0, 34'd0, 7'd0, 1'b0, 1'b1, inx};
        else              return {s, rnd[W-1:0], 7'(e), 1'b0, 1'b0, inx};
    endfunction

    // driver: one full operation with a bounded wait for done
    task automatic run_op(input logic sa, input logic sb, input logic [W-1:0] ma,
                          input logic [W-1:0] mb, input logic [EW-1:0] ea,
                          input logic [EW-1:0] eb, input logic [44:0] expv, input int lat);
        int seen;
        seen = -1;
        @(negedge clock);
        signA = sa; signB = sb; mantA = ma; mantB = mb; expA = ea; expB = eb;
        exp_q.push_back(expv);
        eval = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clock);
            #1;
            if (i == 0) check("busy_after_accept", busy, 1);
            if (done) begin
                seen = i;
                break;
            end
        end
        if (seen < 0) check("done_timeout", 0, 1);
        else if (lat >= 0) check("latency", seen, lat);
        @(negedge clock);
        eval = 1'b0;
        @(negedge clock);
    endtask

    // scoreboard / compare process
    always @(negedge clock) begin
        if (!reset) begin
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("spurious_done", 1, 0);
                end else begin
                    logic [44:0] e;
                    e = exp_q.pop_front();
                    check("result", out_vec(), e);
                    check("busy_at_done", busy, 0);
                    last_res = e;
                end
            end else if (!busy) begin
                check("hold", out_vec(), last_res);
            end
        end
    end

    initial begin
        logic [44:0] expv;
        logic [W-1:0] ma, mb;
        logic [EW-1:0] ea, eb;
        logic sa, sb;
        int kfl, lat, dcnt;
        bit rr;

        reset = 1'b1; eval = 1'b0;
        signA = 1'b0; signB = 1'b0; mantA = '0; mantB = '0; expA = '0; expB = '0;
        repeat (3) @(negedge clock);
        check("reset_outputs", out_vec(), 0);
        check("reset_done", done, 0);
        reset = 1'b0;
        @(negedge clock);
        check("reset_busy", busy, 0);
        check("reset_state", stateDbg, S_IDLE);

        // pin the reference model with hand-computed values
        check("pin_basic", model(0, 0, 34'd3, 34'd4, 0, 0, kfl, rr), {1'b0, 34'd12, 7'd0, 3'b000});
        check("pin_round", model(1, 0, 34'd10000000005, 34'd3, 0, 0, kfl, rr),
              {1'b1, 34'd3000000002, 7'd1, 3'b001});
        check("pin_ovf", model(0, 0, 34'd2, 34'd3, 60, 60, kfl, rr),
              {1'b0, 34'd17179869183, 7'd63, 3'b100});
        check("pin_reround", model(0, 0, 34'd1397635, 34'd122921, 0, 0, kfl, rr),
              {1'b0, 34'd1717986918, 7'd2, 3'b001});
        check("pin_reround_flag", rr, 1);

        // directed test-plan cases
        run_op(0, 0, 34'd3, 34'd4, 7'd0, 7'd0, {1'b0, 34'd12, 7'd0, 3'b000}, 38);
        run_op(0, 0, 34'd10000000000, 34'd3, 7'd0, 7'd0, {1'b0, 34'd3000000000, 7'd1, 3'b000}, 39);
        run_op(1, 0, 34'd10000000005, 34'd3, 7'd0, 7'd0, {1'b1, 34'd3000000002, 7'd1, 3'b001}, 39);
        run_op(1, 0, 34'd0, 34'd7, 7'd5, 7'd3, 45'd0, 1);
        run_op(0, 0, 34'd2, 34'd3, 7'd60, 7'd60, {1'b0, 34'd17179869183, 7'd63, 3'b100}, 38);
        run_op(0, 0, 34'd2, 34'd3, 7'(-60), 7'(-60), {1'b0, 34'd0, 7'd0, 3'b010}, 38);
        run_op(0, 1, 34'd1397635, 34'd122921, 7'd0, 7'd0, {1'b1, 34'd1717986918, 7'd2, 3'b001}, -1);

        // a second eval edge during S_MUL must be ignored
        @(negedge clock);
        signA = 0; signB = 0; mantA = 34'd3; mantB = 34'd4; expA = 7'd2; expB = 7'd1;
        exp_q.push_back({1'b0, 34'd12, 7'd3, 3'b000});
        eval = 1'b1;
        repeat (5) @(negedge clock);
        eval = 1'b0;
        @(negedge clock);
        eval = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 90; i++) begin
            @(negedge clock);
            if (done) dcnt++;
        end
        check("single_done", dcnt, 1);
        eval = 1'b0;
        @(negedge clock);

        // reset while normalizing aborts the operation
        @(negedge clock);
        mantA = 34'h3_FFFF_FFFF; mantB = 34'h3_FFFF_FFFF; expA = 7'd0; expB = 7'd0;
        exp_q.push_back('0);
        eval = 1'b1;
        repeat (38) @(posedge clock);
        @(negedge clock);
        check("in_norm", stateDbg, S_NORM);
        reset = 1'b1;
        eval  = 1'b0;
        #1;
        check("abort_outputs", out_vec(), 0);
        check("abort_busy", busy, 0);
        exp_q.delete();
        last_res = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (done) dcnt++;
        end
        check("no_done_after_abort", dcnt, 0);

        run_op(0, 1, 34'd25, 34'd4, 7'd1, 7'd2, {1'b1, 34'd100, 7'd3, 3'b000}, 38);

        // randomized operands against the model
        for (int n = 0; n < 150; n++) begin
            sa = 1'($urandom);
            sb = 1'($urandom);
            ma = 34'({$urandom, $urandom}) >> $urandom_range(0, 33);
            mb = 34'({$urandom, $urandom}) >> $urandom_range(0, 33);
            if ($urandom_range(0, 15) == 0) ma = '0;
            if ($urandom_range(0, 15) == 0) mb = '0;
            if ($urandom_range(0, 1) == 1) begin
                ea = 7'($urandom_range(0, 16)) - 7'd8;
                eb = 7'($urandom_range(0, 16)) - 7'd8;
            end else begin
                ea = 7'($urandom);
                eb = 7'($urandom);
            end
            expv = model(sa, sb, ma, mb, int'($signed(ea)), int'($signed(eb)), kfl, rr);
            if (ma == '0 || mb == '0) lat = 1;
            else if (rr) lat = -1;
            else lat = W + kfl + 4;
            run_op(sa, sb, ma, mb, ea, eb, expv, lat);
        end

        repeat (3) @(negedge clock);
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dec_mul_seq.md
# dec_mul_seq

Parametrised sequential decimal floating-point multiplier for the calculator datapath. It computes (-1)^s·m·10^e operands into a normalized product using a radix-2 shift-add mantissa multiply. Normalization divides by 10, then applies round-half-up, exponent range checking and zero short-circuit. It sits beside the adder in the function unit and uses the same eval/done handshake.

## Interface
- MANT_W, 34, mantissa width. M_MAX = 2^MANT_W − 1. Minimum 4.
- EXP_W, 7, signed exponent width. E_MAX = 2^(EXP_W−1) − 1, E_MIN = −2^(EXP_W−1). Minimum 3.
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- eval  in  1  level input. Its rising edge starts an operation.
- signA, signB  in  1  operand signs. 1 means negative.
- mantA, mantB  in  MANT_W  unsigned operand mantissas.
- expA, expB  in  EXP_W signed  base-10 operand exponents.
- busy  out  1  high from the cycle after an accepted edge until done.
- done  out  1  one-cycle pulse; result outputs are valid from this point.
- signRes  out  1  result sign.
- mantRes  out  MANT_W  result mantissa, always ≤ M_MAX.
- expRes  out  EXP_W signed  result exponent.
- ovf, unf, inexact  out  1 each  status flags, valid with done.

## Operation
- Reset values: all outputs 0, state S_IDLE, eval edge register 0.
- Edge detect: doEval = eval & ~evalPrev. evalPrev updates every non-reset cycle.
- S_IDLE, doEval:
  - Latch both operands.
  - If either mantissa is 0: result is sign 0, mant 0, exp 0, all flags 0; go to S_DONE.
  - Otherwise clear the product and go to S_MUL.
- Edges while busy are ignored; the operation is not restarted.
- S_MUL: MANT_W cycles of shift-add using a bit counter.
  - Product register is 2·MANT_W bits.
  - Sign = signA ^ signB.
  - Exponent sum is held in EXP_W+2 signed bits, so it never wraps.
- S_NORM: one step per cycle.
  - If prod > M_MAX: prod ← prod/10, exp ← exp+1, rdig ← prod%10, sticky ← sticky | (old rdig ≠ 0).
  - Else go to S_ROUND.
- S_ROUND:
  - If rdig ≥ 5, prod ← prod+1.
  - inexact ← sticky | (rdig ≠ 0).
  - If the rounded prod > M_MAX, clear rdig and return to S_NORM; otherwise go to S_PACK.
- S_PACK, range check:
  - exp > E_MAX: ovf=1, mantRes=M_MAX, expRes=E_MAX, sign kept.
  - exp < E_MIN: unf=1, mantRes=0, expRes=0, signRes=0.
  - Otherwise write the result directly.
- S_DONE: done=1, go to S_IDLE.
- Outputs hold their values until the next completed operation.
- No mantissa pre-normalization: results are not scaled up to maximize digits.

## Timing
- Edge 0 is the clock edge at which doEval is sampled high in S_IDLE.
- Zero path: done is high in the cycle after edge 1.
- Normal path: done is high after edge MANT_W + k + 4, where k = number of ÷10 steps. Add k'+1 if rounding re-enters S_NORM.
- busy is low exactly when state = S_IDLE. It falls in the same cycle done rises.
- A new eval edge is accepted in the cycle after done at the earliest.
- Reset mid-operation aborts immediately: state S_IDLE, outputs 0, no done.

## Structure
- Package calc_pkg holds:
  - default MANT_W/EXP_W localparams;
  - the state_t enum: S_IDLE, S_MUL, S_NORM, S_ROUND, S_PACK, S_DONE;
  - a dec_flags_t struct with fields ovf, unf, inexact.
- Sub-module dec_div10: combinational, parametrised width, outputs quotient and 4-bit remainder. It is reused later by the divider and the binary-to-digit formatter.

## Test plan
All cases use MANT_W=34, EXP_W=7.
- Basic multiply: 3·10^0 × 4·10^0 → mant 12, exp 0, sign 0, flags 0. done high after edge 38.
- Exact normalization: 10000000000 × 3, exp 0/0 → mant 3000000000, exp 1, inexact 0.
- Rounding: 10000000005 × 3, signs 1/0 → prod 30000000015, giving mant 3000000002, exp 1, sign 1, inexact 1.
- Zero: mantA 0, signA 1, × 7 → sign 0, mant 0, exp 0. done after edge 1; no S_MUL cycles.
- Range:
  - 2·10^60 × 3·10^60 → ovf 1, mant 17179869183, exp 63.
  - 2·10^−60 × 3·10^−60 → unf 1, mant 0, exp 0.
- Control:
  - A second eval edge during S_MUL is ignored; exactly one done pulse.
  - reset during S_NORM → outputs 0, no done.
  - A following eval completes normally.
